// File: rtl/stage_if.sv
// Multithreaded instruction-fetch stage: per-thread PCs, round-robin thread pick, IF/ID register.
// Define STAGE_IF_RR_SKIP_EN for a work-conserving arbiter; the default build uses strict rotation.
package common;
  localparam int n_threads = 4;
  typedef logic [31:0] vptr_t;
  typedef logic [31:0] word_t;
  typedef logic [$clog2(n_threads)-1:0] threadid_t;
endpackage

module stage_if #(
  parameter common::vptr_t RESET_PC  = 32'h0000_1000,
  parameter common::word_t NOP_INSTR = 32'h0000_0000
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              stall_i,
  output common::vptr_t     ic_addr_o,
  output logic              ic_req_o,
  output common::threadid_t ic_thread_o,
  input  logic              itlb_miss_i,
  input  logic              ic_hit_i,
  input  common::word_t     ic_data_i,
  input  logic              ic_fill_done_i,
  input  common::threadid_t ic_fill_thread_i,
  input  logic              ex_redirect_i,
  input  common::threadid_t ex_redirect_thread_i,
  input  common::vptr_t     ex_redirect_pc_i,
  input  common::word_t     rm4_i [common::n_threads],
  output logic              id_itlb_miss_o,
  output logic              id_icache_miss_o,
  output common::vptr_t     id_pc_o,
  output common::word_t     id_instruction_o,
  output common::threadid_t id_thread_o,
  output common::word_t     id_rm4_o
);
  import common::*;

  localparam int NT = n_threads;

  vptr_t         pc_q [NT];
  vptr_t         pc_d [NT];
  logic [NT-1:0] waiting_q, waiting_d;
  logic [NT-1:0] blocked_q, blocked_d;
  threadid_t     last_q, last_d;
  logic          id_itlb_miss_q, id_itlb_miss_d;
  logic          id_icache_miss_q, id_icache_miss_d;
  vptr_t         id_pc_q, id_pc_d;
  word_t         id_instruction_q, id_instruction_d;
  threadid_t     id_thread_q, id_thread_d;
  word_t         id_rm4_q, id_rm4_d;

  logic [NT-1:0] eligible;
  threadid_t     grant;
  logic          grant_vld;
  logic          fire;

  // A thread being redirected this cycle is held off so it restarts from the new PC.
  always_comb begin
    eligible = '0;
    for (int t = 0; t < NT; t++) begin
      eligible[t] = !waiting_q[t] && !blocked_q[t] &&
                    !(ex_redirect_i && (ex_redirect_thread_i == threadid_t'(t)));
    end
  end

`ifdef STAGE_IF_RR_SKIP_EN
  // Scan farthest-to-nearest so the nearest eligible thread after last_q wins.
  always_comb begin
    threadid_t idx;
    idx       = '0;
    grant     = last_q;
    grant_vld = 1'b0;
    for (int k = NT; k >= 1; k--) begin
      idx = threadid_t'((int'(last_q) + k) % NT);
      if (eligible[idx]) begin
        grant     = idx;
        grant_vld = 1'b1;
      end
    end
  end
`else
  always_comb begin
    grant     = threadid_t'((int'(last_q) + 1) % NT);
    grant_vld = eligible[grant];
  end
`endif

  assign fire        = grant_vld && !stall_i;
  assign ic_req_o    = fire && !rst_i;
  assign ic_addr_o   = pc_q[grant];
  assign ic_thread_o = grant;

  // Fill-done first, fetch outcome next, redirect last so it overrides everything for its thread.
  always_comb begin
    pc_d             = pc_q;
    waiting_d        = waiting_q;
    blocked_d        = blocked_q;
    last_d           = last_q;
    id_itlb_miss_d   = id_itlb_miss_q;
    id_icache_miss_d = id_icache_miss_q;
    id_pc_d          = id_pc_q;
    id_instruction_d = id_instruction_q;
    id_thread_d      = id_thread_q;
    id_rm4_d         = id_rm4_q;

    if (ic_fill_done_i) waiting_d[ic_fill_thread_i] = 1'b0;

    if (!stall_i) begin
`ifdef STAGE_IF_RR_SKIP_EN
      if (grant_vld) last_d = grant;
`else
      last_d = grant;
`endif
      if (grant_vld) begin
        id_thread_d = grant;
        id_pc_d     = pc_q[grant];
        id_rm4_d    = rm4_i[grant];
        if (itlb_miss_i) begin
          blocked_d[grant] = 1'b1;
          id_itlb_miss_d   = 1'b1;
          id_icache_miss_d = 1'b0;
          id_instruction_d = NOP_INSTR;
        end else if (ic_hit_i) begin
          pc_d[grant]      = pc_q[grant] + 32'd4;
          id_itlb_miss_d   = 1'b0;
          id_icache_miss_d = 1'b0;
          id_instruction_d = ic_data_i;
        end else begin
          waiting_d[grant] = 1'b1;
          id_itlb_miss_d   = 1'b0;
          id_icache_miss_d = 1'b1;
          id_instruction_d = NOP_INSTR;
        end
      end else begin
        id_itlb_miss_d   = 1'b0;
        id_icache_miss_d = 1'b1;
        id_instruction_d = NOP_INSTR;
      end
    end

    if (ex_redirect_i) begin
      pc_d[ex_redirect_thread_i]      = ex_redirect_pc_i;
      waiting_d[ex_redirect_thread_i] = 1'b0;
      blocked_d[ex_redirect_thread_i] = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc_q             <= '{default: RESET_PC};
      waiting_q        <= '0;
      blocked_q        <= '0;
      last_q           <= threadid_t'(NT - 1);
      id_itlb_miss_q   <= 1'b0;
      id_icache_miss_q <= 1'b1;
      id_pc_q          <= '0;
      id_instruction_q <= NOP_INSTR;
      id_thread_q      <= '0;
      id_rm4_q         <= '0;
    end else begin
      pc_q             <= pc_d;
      waiting_q        <= waiting_d;
      blocked_q        <= blocked_d;
      last_q           <= last_d;
      id_itlb_miss_q   <= id_itlb_miss_d;
      id_icache_miss_q <= id_icache_miss_d;
      id_pc_q          <= id_pc_d;
      id_instruction_q <= id_instruction_d;
      id_thread_q      <= id_thread_d;
      id_rm4_q         <= id_rm4_d;
    end
  end

  assign id_itlb_miss_o   = id_itlb_miss_q;
  assign id_icache_miss_o = id_icache_miss_q;
  assign id_pc_o          = id_pc_q;
  assign id_instruction_o = id_instruction_q;
  assign id_thread_o      = id_thread_q;
  assign id_rm4_o         = id_rm4_q;
endmodule

// File: doc/stage_if.md
# stage_if

Instruction-fetch stage of the multithreaded pipeline.
- Holds one PC per hardware thread and picks one ready thread per cycle with a round-robin arbiter.
- Presents that thread's PC to the iTLB/icache and registers the result into the IF/ID pipeline register consumed by `stage_id`.
- Tracks per-thread icache-miss waits and iTLB-miss blocks, and applies PC redirects coming back from EX.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_1000, PC loaded into every thread on reset.
- `NOP_INSTR`, 32'h0000_0000, instruction word driven on bubbles.

Thread count is `common::n_threads`. Types from `common`: `vptr_t`/`word_t` are 32 bits; `threadid_t` is $clog2(n_threads) bits.

Ports:
- Clocking and control:
  - `clk` in 1 — single clock, rising edge.
  - `rst` in 1 — asynchronous, active-high reset.
  - `stall` in 1 — downstream stall; freezes all state and outputs.
- iTLB / icache:
  - `ic_addr` out vptr_t — fetch virtual address (combinational from the selected PC).
  - `ic_req` out 1 — fetch request this cycle.
  - `ic_thread` out threadid_t — thread of the request.
  - `itlb_miss` in 1 — same-cycle iTLB miss response.
  - `ic_hit` in 1 — same-cycle icache hit.
  - `ic_data` in word_t — instruction word, valid when `ic_hit`.
  - `ic_fill_done` in 1 — line fill completed.
  - `ic_fill_thread` in threadid_t — thread whose miss was filled.
- EX redirect:
  - `ex_redirect` in 1 — redirect request.
  - `ex_redirect_thread` in threadid_t — thread to redirect.
  - `ex_redirect_pc` in vptr_t — new PC.
- Special registers:
  - `rm4` in word_t[n_threads] — per-thread rm4 special register.
- IF/ID outputs:
  - `id_itlb_miss` out 1 — fetched PC missed in the iTLB.
  - `id_icache_miss` out 1 — miss or bubble; tells the HZU the slot is invalid.
  - `id_pc` out vptr_t — PC of the fetched instruction.
  - `id_instruction` out word_t — instruction word.
  - `id_thread` out threadid_t — thread of the fetched instruction.
  - `id_rm4` out word_t — `rm4[id_thread]` sampled at fetch.

## Operation
Per-thread state:
- `pc[t]`
- `waiting[t]` — outstanding icache miss.
- `blocked[t]` — iTLB miss sent down the pipe, waiting for the EX exception redirect.
- Arbiter pointer `last`.

Eligibility: thread t is eligible when `!waiting[t] && !blocked[t] && !(ex_redirect && ex_redirect_thread==t)`.

Grant: the first eligible thread scanning from `last+1` modulo n_threads. `ic_req=1` iff a grant exists and `!stall`.

Outcome for granted thread g, when not stalled:
- iTLB miss (`itlb_miss`):
  - Set `blocked[g]`; `pc[g]` unchanged.
  - IF/ID gets `id_itlb_miss=1`, `id_icache_miss=0`, `id_pc=pc[g]`, `id_instruction=NOP_INSTR`.
- Icache hit (`!itlb_miss && ic_hit`):
  - `pc[g] <= pc[g]+4`, wrapping mod 2^32.
  - IF/ID gets `id_instruction=ic_data`, both miss flags 0.
- Icache miss (`!itlb_miss && !ic_hit`):
  - Set `waiting[g]`; `pc[g]` unchanged.
  - IF/ID gets `id_icache_miss=1`, `id_instruction=NOP_INSTR`.
- In all three cases, `last <= g`.

No grant (bubble): IF/ID gets `id_icache_miss=1`, `id_itlb_miss=0`, `id_instruction=NOP_INSTR`; `id_thread`/`id_pc` hold their previous values.

`ic_fill_done` clears `waiting[ic_fill_thread]`; it is ignored if that bit is not set.

`ex_redirect` (applied even during `stall`):
- `pc[ex_redirect_thread] <= ex_redirect_pc`.
- Clears both `waiting` and `blocked` for that thread.
- Redirect overrides a fill-done for the same thread in the same cycle.
- A later fill-done for that thread is harmless.

`stall`: no PC/flag/`last` update except redirect and fill-done; IF/ID outputs hold.

## Timing
- Fetch latency: one cycle. A PC selected in cycle N appears on `id_*` after edge N+1.
- Icache and iTLB answer combinationally within the request cycle.
- A redirect in cycle N makes the thread eligible in cycle N+1 with the new PC.
- A fill-done in cycle N makes the thread eligible in cycle N+1.
- Reset (async, any time, including mid-miss):
  - `pc[*]=RESET_PC`; `waiting=0`; `blocked=0`; `last=n_threads-1`, so thread 0 is granted first.
  - `id_pc=0`, `id_instruction=NOP_INSTR`, `id_icache_miss=1`, `id_itlb_miss=0`, `id_thread=0`, `id_rm4=0`.
  - `ic_req=0` while `rst` is high.

## Configuration
`STAGE_IF_RR_SKIP_EN`:
- Defined: the arbiter skips ineligible threads as described above (work-conserving).
- Undefined: strict rotation. `g=last+1` every non-stalled cycle and `last` always advances. If g is ineligible the slot is a bubble and `ic_req=0`.

## Test plan
- Reset release, 4 threads, all hits: grants 0,1,2,3,0; `id_pc` 0x1000 ×4, then 0x1004 for thread 0; `id_rm4` matches per thread.
- Thread 1 misses in the icache: `id_icache_miss=1` and `id_pc=0x1000` for thread 1.
  - With the macro, grants go 2,3,0,2…; without it, thread 1's slots are bubbles.
  - `ic_fill_done` for thread 1 in cycle N → thread 1 is refetched at 0x1000 in N+1 or its next slot.
- iTLB miss on thread 2: `id_itlb_miss=1` once; thread 2 is never granted until `ex_redirect` (thread 2, 0x2000); its next fetch has `id_pc=0x2000`.
- Redirect of thread 0 to 0x3000 in the same cycle thread 0 would be granted: thread 0 is not fetched that cycle; its next fetch has `id_pc=0x3000`.
- `stall` held 3 cycles mid-stream: `id_*` constant, no PC advance, `ic_req=0`; a redirect during the stall is still applied.
- Async `rst` pulse while thread 3 is waiting: all outputs return to reset values immediately; after release thread 3 fetches 0x1000 without any fill.
